// File: rtl/dmem_arbiter_if.sv
// Bundles the CPU load/store path, the host port and the data-memory side of dmem_arbiter.
// "slave" is the arbiter's view; "master" is the surrounding datapath, host and memory.
interface dmem_arbiter_if #(
   parameter int DATA_W = 32
);
   logic              cpu_memRead;
   logic              cpu_memWrite;
   logic [DATA_W-1:0] cpu_address;
   logic [DATA_W-1:0] cpu_write_Data;
   logic [DATA_W-1:0] cpu_read_Data;
   logic              cpu_stall;

   logic              host_req;
   logic              host_we;
   logic [DATA_W-1:0] host_addr;
   logic [DATA_W-1:0] host_wdata;
   logic              host_ack;
   logic [DATA_W-1:0] host_rdata;

   logic [DATA_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_write_Data;
   logic              mem_memRead;
   logic              mem_memWrite;
   logic [DATA_W-1:0] mem_read_Data;

   modport slave (
      input  cpu_memRead, cpu_memWrite, cpu_address, cpu_write_Data,
      output cpu_read_Data, cpu_stall,
      input  host_req, host_we, host_addr, host_wdata,
      output host_ack, host_rdata,
      output mem_address, mem_write_Data, mem_memRead, mem_memWrite,
      input  mem_read_Data
   );

   modport master (
      output cpu_memRead, cpu_memWrite, cpu_address, cpu_write_Data,
      input  cpu_read_Data, cpu_stall,
      output host_req, host_we, host_addr, host_wdata,
      input  host_ack, host_rdata,
      input  mem_address, mem_write_Data, mem_memRead, mem_memWrite,
      output mem_read_Data
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU has priority, host gets idle slots or is forced in after MAX_WAIT blocked cycles.
// Optional macro DMEM_ARB_STATS_EN adds saturating host-cycle and stall-cycle counters.
module dmem_arbiter #(
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic                clk,
   input  logic                reset,
   dmem_arbiter_if.slave       bus
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [15:0]         stat_host_cnt,
   output logic [15:0]         stat_stall_cnt
`endif
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HOST = 2'd1,
      S_ACK  = 2'd2
   } state_t;

   localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

   state_t            r_state;
   state_t            w_next_state;
   logic [3:0]        r_wait_cnt;
   logic [3:0]        w_next_wait;
   logic [DATA_W-1:0] r_host_rdata;
   logic              w_cpu_acc;
   logic              w_host_own;

   assign w_cpu_acc  = bus.cpu_memRead | bus.cpu_memWrite;
   // Reset kills the host access already in its HOST cycle, including its memory strobe.
   assign w_host_own = (r_state == S_HOST) && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_wait_cnt   <= 4'd0;
         r_host_rdata <= '0;
      end else begin
         r_state    <= w_next_state;
         r_wait_cnt <= w_next_wait;
         if ((r_state == S_HOST) && !bus.host_we) begin
            r_host_rdata <= bus.mem_read_Data;
         end
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_next_wait  = 4'd0;
      case (r_state)
         S_IDLE: begin
            if (bus.host_req && (!w_cpu_acc || (r_wait_cnt == MAX_WAIT_C))) begin
               w_next_state = S_HOST;
            end else if (bus.host_req && w_cpu_acc) begin
               w_next_wait = (r_wait_cnt == MAX_WAIT_C) ? r_wait_cnt : r_wait_cnt + 4'd1;
            end
         end
         S_HOST:  w_next_state = S_ACK;
         S_ACK:   w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      bus.mem_address    = bus.cpu_address;
      bus.mem_write_Data = bus.cpu_write_Data;
      bus.mem_memRead    = bus.cpu_memRead;
      bus.mem_memWrite   = bus.cpu_memWrite;
      bus.cpu_read_Data  = bus.mem_read_Data;
      bus.cpu_stall      = 1'b0;
      if (w_host_own) begin
         bus.mem_address    = bus.host_addr;
         bus.mem_write_Data = bus.host_wdata;
         bus.mem_memRead    = !bus.host_we;
         bus.mem_memWrite   = bus.host_we;
         bus.cpu_read_Data  = '0;
         bus.cpu_stall      = w_cpu_acc;
      end
      bus.host_ack   = (r_state == S_ACK) && !reset;
      bus.host_rdata = r_host_rdata;
   end

`ifdef DMEM_ARB_STATS_EN
   logic [15:0] r_stat_host_cnt;
   logic [15:0] r_stat_stall_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stat_host_cnt  <= 16'd0;
         r_stat_stall_cnt <= 16'd0;
      end else begin
         if (w_host_own && (r_stat_host_cnt != 16'hFFFF)) begin
            r_stat_host_cnt <= r_stat_host_cnt + 16'd1;
         end
         if (bus.cpu_stall && (r_stat_stall_cnt != 16'hFFFF)) begin
            r_stat_stall_cnt <= r_stat_stall_cnt + 16'd1;
         end
      end
   end

   assign stat_host_cnt  = r_stat_host_cnt;
   assign stat_stall_cnt = r_stat_stall_cnt;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed host/CPU scenarios, host_ack results checked by a scoreboard monitor.
// Stat counters are checked only when DMEM_ARB_STATS_EN is defined.
module tb_dmem_arbiter;

   logic clk;
   logic reset;
   int   checks;
   int   passed;

   logic [31:0] expQ[$];
   logic [31:0] memArr [0:255];

   dmem_arbiter_if #(.DATA_W(32)) bus ();

`ifdef DMEM_ARB_STATS_EN
   logic [15:0] statHost;
   logic [15:0] statStall;
`endif

   dmem_arbiter #(
      .DATA_W   (32),
      .MAX_WAIT (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef DMEM_ARB_STATS_EN
      ,
      .stat_host_cnt  (statHost),
      .stat_stall_cnt (statStall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Word-addressed behavioural data memory: combinational read, write on rising edge.
   assign bus.mem_read_Data = memArr[bus.mem_address[9:2]];
   always @(posedge clk) begin
      if (bus.mem_memWrite === 1'b1) begin
         memArr[bus.mem_address[9:2]] <= bus.mem_write_Data;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual === expected) begin
         passed++;
      end else begin
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic cRd, input logic cWr, input logic [31:0] cAddr,
                                input logic [31:0] cData, input logic hReq, input logic hWe,
                                input logic [31:0] hAddr, input logic [31:0] hData);
      bus.cpu_memRead    = cRd;
      bus.cpu_memWrite   = cWr;
      bus.cpu_address    = cAddr;
      bus.cpu_write_Data = cData;
      bus.host_req       = hReq;
      bus.host_we        = hWe;
      bus.host_addr      = hAddr;
      bus.host_wdata     = hData;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: every host_ack must match the oldest expected host_rdata.
   always @(negedge clk) begin
      logic [31:0] expVal;
      if (bus.host_ack === 1'b1) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected host_ack", 32'd1, 32'd0);
         end else begin
            expVal = expQ.pop_front();
            checkOutput("host_rdata at ack", bus.host_rdata, expVal);
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      checks = 0;
      passed = 0;
      for (int i = 0; i < 256; i++) memArr[i] = 32'h0;
      memArr[8'h10] = 32'hDEADBEEF;
      memArr[8'h11] = 32'h44444444;
      memArr[8'h40] = 32'hC0FFEE00;

      // Reset held with a pending host request: nothing may be granted.
      reset = 1'b1;
      applyStimulus(1'b1, 1'b0, 32'h10, 32'hAA, 1'b1, 1'b0, 32'h40, 32'h0);
      tick();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("reset host_ack", 32'(bus.host_ack), 32'd0);
         checkOutput("reset cpu_stall", 32'(bus.cpu_stall), 32'd0);
         checkOutput("reset host_rdata", bus.host_rdata, 32'h0);
         checkOutput("reset mem_address", bus.mem_address, 32'h10);
         checkOutput("reset mem_memRead", 32'(bus.mem_memRead), 32'd1);
         checkOutput("reset mem_memWrite", 32'(bus.mem_memWrite), 32'd0);
         tick();
      end
      reset = 1'b0;

      // Idle-slot host read of 0x40.
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
      expQ.push_back(32'hDEADBEEF);
      @(negedge clk);
      checkOutput("idle req cpu_stall", 32'(bus.cpu_stall), 32'd0);
      checkOutput("idle req host_ack", 32'(bus.host_ack), 32'd0);
      tick();
      @(negedge clk);
      checkOutput("host rd mem_address", bus.mem_address, 32'h40);
      checkOutput("host rd mem_memRead", 32'(bus.mem_memRead), 32'd1);
      checkOutput("host rd mem_memWrite", 32'(bus.mem_memWrite), 32'd0);
      checkOutput("host rd cpu_stall", 32'(bus.cpu_stall), 32'd0);
      tick();
      @(negedge clk);
      checkOutput("idle read ack latency", 32'(bus.host_ack), 32'd1);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      checkOutput("ack one cycle", 32'(bus.host_ack), 32'd0);
      checkOutput("host_rdata held", bus.host_rdata, 32'hDEADBEEF);

      // Host write blocked by continuous CPU loads until forced after 4 waits.
      tick();
      applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b1, 32'h80, 32'h12345678);
      expQ.push_back(32'hDEADBEEF);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("blocked cpu_stall", 32'(bus.cpu_stall), 32'd0);
         checkOutput("blocked cpu_read_Data", bus.cpu_read_Data, 32'hC0FFEE00);
         checkOutput("blocked mem_address", bus.mem_address, 32'h100);
         tick();
      end
      @(negedge clk);
      checkOutput("forced cpu_stall", 32'(bus.cpu_stall), 32'd1);
      checkOutput("forced mem_memWrite", 32'(bus.mem_memWrite), 32'd1);
      checkOutput("forced mem_memRead", 32'(bus.mem_memRead), 32'd0);
      checkOutput("forced mem_address", bus.mem_address, 32'h80);
      checkOutput("forced mem_write_Data", bus.mem_write_Data, 32'h12345678);
      checkOutput("forced cpu_read_Data", bus.cpu_read_Data, 32'h0);
      tick();
      @(negedge clk);
      checkOutput("forced ack", 32'(bus.host_ack), 32'd1);
      checkOutput("ack cpu_stall", 32'(bus.cpu_stall), 32'd0);
      checkOutput("ack mem_address", bus.mem_address, 32'h100);
`ifdef DMEM_ARB_STATS_EN
      // Two HOST cycles so far (idle-slot read and forced write), one stalled cycle.
      checkOutput("stat_host_cnt", 32'(statHost), 32'd2);
      checkOutput("stat_stall_cnt", 32'(statStall), 32'd1);
`endif
      tick();

      // Reset during the HOST cycle of a write to 0x44: no ack, no memory write.
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h44, 32'hBAD0BAD0);
      tick();
      reset = 1'b1;
      @(negedge clk);
      checkOutput("reset in HOST mem_memWrite", 32'(bus.mem_memWrite), 32'd0);
      checkOutput("reset in HOST cpu_stall", 32'(bus.cpu_stall), 32'd0);
      checkOutput("reset in HOST host_ack", 32'(bus.host_ack), 32'd0);
      tick();
      reset = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("dropped txn host_ack", 32'(bus.host_ack), 32'd0);
         tick();
      end

      // Back-to-back reads of 0x80 with host_req held through ACK.
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0);
      expQ.push_back(32'h12345678);
      expQ.push_back(32'h12345678);
      tick();
      @(negedge clk);
      checkOutput("b2b first HOST mem_memRead", 32'(bus.mem_memRead), 32'd1);
      tick();
      @(negedge clk);
      checkOutput("b2b first ack", 32'(bus.host_ack), 32'd1);
      checkOutput("b2b ACK cpu owns memory", 32'(bus.mem_memRead), 32'd0);
      tick();
      @(negedge clk);
      checkOutput("b2b IDLE host_ack", 32'(bus.host_ack), 32'd0);
      checkOutput("b2b IDLE cpu owns memory", 32'(bus.mem_memRead), 32'd0);
      tick();
      @(negedge clk);
      checkOutput("b2b second HOST mem_memRead", 32'(bus.mem_memRead), 32'd1);
      checkOutput("b2b second HOST mem_address", bus.mem_address, 32'h80);
      tick();
      @(negedge clk);
      checkOutput("b2b second ack", 32'(bus.host_ack), 32'd1);
      tick();

      // Read back 0x44: the write killed by reset must not have landed.
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0);
      expQ.push_back(32'h44444444);
      tick();
      tick();
      @(negedge clk);
      checkOutput("readback ack", 32'(bus.host_ack), 32'd1);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      tick();
      @(negedge clk);
      checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);

      $display("[TB] %0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
